// File: rtl/mem_stage.sv
// mem_stage: byte/half/word load-store stage over a synchronous data RAM; MEM_ALIGN_CHECK_EN adds misalignment errors
module mem_stage #(
    parameter int N = 32,
    parameter int DEPTH = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] alu_out,
    input  logic [N-1:0] rs2_data,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [2:0]   fn3,
    output logic [N-1:0] load_data,
    output logic         load_valid,
    output logic         stall,
    output logic         access_err
);
    localparam logic [0:0] IDLE = 1'b0, WAIT = 1'b1;
    logic [0:0] state;
    logic [N-1:0] ram [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [1:0] off;
    logic bad_op, misal, ld_go, st_go, unused_hi;
    logic [3:0] be;
    logic [N-1:0] wdata, word, ext;
    logic [7:0] byte_v;
    logic [15:0] half_v;
    assign idx = alu_out[ADDR_W+1:2];
    assign off = alu_out[1:0];
    assign unused_hi = ^alu_out[N-1:ADDR_W+2];
    assign bad_op = (mem_read & mem_write)
                  | (mem_read & (fn3 == 3'b011 | fn3[2:1] == 2'b11))
                  | (mem_write & (fn3[2] | fn3[1:0] == 2'b11));
`ifdef MEM_ALIGN_CHECK_EN
    assign misal = (mem_read | mem_write)
                 & ((fn3[1:0] == 2'b01 & off[0]) | (fn3[1:0] == 2'b10 & off != 2'b00));
`else
    assign misal = 1'b0;
`endif
    assign access_err = state == IDLE & (bad_op | misal);
    assign ld_go = state == IDLE & mem_read & ~mem_write & ~bad_op & ~misal;
    assign st_go = state == IDLE & mem_write & ~mem_read & ~bad_op & ~misal & ~rst;
    assign stall = ld_go;
    // Lanes follow the byte offset; halves and words ignore the low bits they cannot address
    assign be = fn3[1] ? 4'b1111 : fn3[0] ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
    assign wdata = fn3[1] ? rs2_data : fn3[0] ? {2{rs2_data[15:0]}} : {4{rs2_data[7:0]}};
    assign word = ram[idx];
    assign byte_v = word[{off, 3'b000} +: 8];
    assign half_v = word[{off[1], 4'b0000} +: 16];
    assign ext = fn3[1] ? word
               : fn3[0] ? {{(N-16){half_v[15] & ~fn3[2]}}, half_v}
               : {{(N-8){byte_v[7] & ~fn3[2]}}, byte_v};
    always_ff @(posedge clk) begin
        if (st_go)
            for (int i = 0; i < 4; i++)
                if (be[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            load_data <= '0;
            load_valid <= 1'b0;
        end else begin
            state <= ld_go ? WAIT : IDLE;
            load_valid <= ld_go;
            if (ld_go) load_data <= ext;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed checks of mem_stage against a byte-array model
module tb_mem_stage;
    logic clk = 0, rst = 1, mem_read = 0, mem_write = 0;
    logic [2:0] fn3 = 0;
    logic [31:0] alu_out = 0, rs2_data = 0;
    logic [31:0] load_data;
    logic load_valid, stall, access_err;
    int tests = 0, fails = 0;
    logic [7:0] mem [1024];
    logic [31:0] ld_hold = 0;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    mem_stage dut (.clk(clk), .rst(rst), .alu_out(alu_out), .rs2_data(rs2_data),
                   .mem_read(mem_read), .mem_write(mem_write), .fn3(fn3),
                   .load_data(load_data), .load_valid(load_valid), .stall(stall),
                   .access_err(access_err));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_bad(input bit mr, input bit mw, input logic [2:0] f, input logic [31:0] a);
        bit r = (mr && mw) || (mr && (f == 3 || f == 6 || f == 7)) || (mw && f > 2);
        if (ALIGN && (mr || mw)) r = r || (f[1:0] == 1 && a[0]) || (f[1:0] == 2 && a[1:0] != 0);
        return r;
    endfunction

    function automatic logic [31:0] mload(input logic [31:0] a, input logic [2:0] f);
        logic [9:0] b = a[9:0];
        logic [31:0] r;
        if (f[1:0] == 0) begin
            r = {24'b0, mem[b]};
            if (!f[2]) r = {{24{mem[b][7]}}, mem[b]};
        end else if (f[1:0] == 1) begin
            b[0] = 1'b0;
            r = {16'b0, mem[b | 10'd1], mem[b]};
            if (!f[2]) r = {{16{r[15]}}, r[15:0]};
        end else begin
            b[1:0] = 2'b00;
            r = {mem[b | 10'd3], mem[b | 10'd2], mem[b | 10'd1], mem[b]};
        end
        return r;
    endfunction

    function automatic void mstore(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
        logic [9:0] b = a[9:0];
        if (f == 0) mem[b] = d[7:0];
        else if (f == 1) begin
            b[0] = 1'b0;
            mem[b] = d[7:0];
            mem[b | 10'd1] = d[15:8];
        end else begin
            b[1:0] = 2'b00;
            for (int i = 0; i < 4; i++) mem[b | 10'(i)] = d[8*i +: 8];
        end
    endfunction

    // Called at a negedge in an idle cycle; returns at a negedge ready for the next request
    task automatic op(input bit mr, input bit mw, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        bit err, ld;
        logic [31:0] exp;
        mem_read = mr; mem_write = mw; fn3 = f; alu_out = a; rs2_data = d;
        #1;
        err = is_bad(mr, mw, f, a);
        ld = mr && !mw && !err;
        check("access_err", access_err, err);
        check("stall", stall, ld);
        check("load_valid_idle", load_valid, 0);
        check("load_data_hold", load_data, ld_hold);
        exp = ld ? mload(a, f) : ld_hold;
        if (mw && !mr && !err) mstore(a, f, d);
        @(negedge clk);
        if (ld) begin
            check("wait_valid", load_valid, 1);
            check("wait_stall", stall, 0);
            check("wait_err", access_err, 0);
            check("load_data", load_data, exp);
            ld_hold = exp;
            mem_read = 0; mem_write = 0;
            @(negedge clk);
        end
        mem_read = 0; mem_write = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_load_data", load_data, 0);
        check("rst_load_valid", load_valid, 0);
        check("rst_stall", stall, 0);
        check("rst_access_err", access_err, 0);
        rst = 0;
        for (int i = 0; i < 256; i++) op(0, 1, 3'd2, i * 4, $urandom);
        op(0, 1, 3'd2, 32'h10, 32'hDEADBEEF);
        op(1, 0, 3'd2, 32'h10, 0);
        check("lw_deadbeef", load_data, 32'hDEADBEEF);
        op(0, 1, 3'd0, 32'h21, 32'h80);
        op(1, 0, 3'd0, 32'h21, 0);
        check("lb_sign", load_data, 32'hFFFFFF80);
        op(1, 0, 3'd4, 32'h21, 0);
        check("lbu_zero", load_data, 32'h00000080);
        op(1, 0, 3'd2, 32'h20, 0);
        check("lw_byte1", load_data[15:8], 32'h80);
        op(0, 1, 3'd1, 32'h32, 32'h8001);
        op(1, 0, 3'd1, 32'h32, 0);
        check("lh_sign", load_data, 32'hFFFF8001);
        op(1, 0, 3'd5, 32'h32, 0);
        check("lhu_zero", load_data, 32'h00008001);
        op(1, 0, 3'd2, 32'h13, 0);
        check("lw_misaligned", load_data, ALIGN ? 32'h00008001 : 32'hDEADBEEF);
        op(0, 1, 3'd2, 32'h400, 32'h12345678);
        op(1, 0, 3'd2, 32'h0, 0);
        check("lw_wrap", load_data, 32'h12345678);
        op(1, 1, 3'd2, 32'h0, 32'hFFFFFFFF);
        op(1, 0, 3'd3, 32'h0, 0);
        op(1, 0, 3'd6, 32'h0, 0);
        op(0, 1, 3'd4, 32'h0, 32'hFFFFFFFF);
        op(0, 1, 3'd7, 32'h0, 32'hFFFFFFFF);
        op(0, 0, 3'd0, 32'h0, 0);
        op(1, 0, 3'd2, 32'h0, 0);
        check("illegal_no_write", load_data, 32'h12345678);
        mem_read = 1; fn3 = 3'd2; alu_out = 32'h10;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0; mem_read = 0;
        #1;
        check("rst_wait_valid", load_valid, 0);
        check("rst_wait_data", load_data, 0);
        check("rst_wait_stall", stall, 0);
        ld_hold = 0;
        @(negedge clk);
        op(1, 0, 3'd2, 32'h10, 0);
        check("ram_after_rst", load_data, 32'hDEADBEEF);
        for (int n = 0; n < 400; n++) begin
            int kind;
            logic [2:0] f;
            logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            bit mr, mw;
            kind = $urandom_range(0, 9);
            mr = kind < 4 || kind == 9;
            mw = (kind >= 4 && kind < 7) || kind == 9;
            f = 3'($urandom_range(0, 7));
            if (kind < 4) f = lf[$urandom_range(0, 4)];
            else if (kind < 7) f = 3'($urandom_range(0, 2));
            else if (kind == 8) begin
                mr = $urandom_range(0, 1) == 1;
                mw = !mr;
            end
            op(mr, mw, f, $urandom, $urandom);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
